// File: rtl/rf_read_port_arbiter.sv
// ---------------------------------------------------------------------------
// rf_read_port_arbiter
//
// Shares the single read port of a 32 x 32-bit register file among NREQ
// requesters. A round-robin arbiter grants one valid/ready request per cycle.
// The request then flows through a two-stage pipeline:
//   stage A (issue)    - holds the granted ID/address; a_addr drives rf_addr
//   stage B (response) - captures the register file read data and presents
//                        it on the backpressured response channel
// Responses come back in grant order and are never dropped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_addr     per-requester request (address i at [i*AW +: AW])
//   req_ready              one-hot grant, combinational
//   rf_addr / rf_data      registered read select / combinational read data
//   wr_en/wr_addr/wr_data  register file write port, observed for bypass only
//   rsp_valid/rsp_id/rsp_data/rsp_ready  tagged response channel
//   grant_count            16-bit wrapping count of grants since reset
//
// Optional feature (macro WRITE_BYPASS_EN): when defined, a register file
// write to the address being captured into stage B in the same cycle is
// forwarded to rsp_data. When undefined the write port is ignored.
// ---------------------------------------------------------------------------
module rf_read_port_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]    rf_addr,
  input  logic [DW-1:0]    rf_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [DW-1:0]    rsp_data,
  input  logic             rsp_ready,
  output logic [15:0]      grant_count
);

  // Pipeline state
  logic           a_valid_q;
  logic [IDW-1:0] a_id_q;
  logic [AW-1:0]  a_addr_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [DW-1:0]  rsp_data_q;
  logic [IDW-1:0] ptr_q;
  logic [15:0]    grant_count_q;

  // Combinational helpers
  logic           adv_a;
  logic           adv_b;
  logic           grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_d;
  logic [AW-1:0]  grant_addr;
  logic [DW-1:0]  rsp_data_d;
  int             arb_sum;
  logic [IDW-1:0] arb_idx;

  // Stage B drains when empty or accepted; stage A moves when empty or B moves.
  assign adv_b = !rsp_valid_q || rsp_ready;
  assign adv_a = !a_valid_q || adv_b;

  // Round-robin search starting at ptr_q. Gated by rst_n so nothing is
  // offered while the block is held in reset.
  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant   = 1'b0;
    winner  = '0;
    arb_sum = 0;
    arb_idx = '0;
    if (adv_a && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        arb_sum = int'(ptr_q) + k;
        if (arb_sum >= NREQ) arb_sum = arb_sum - NREQ;
        arb_idx = IDW'(arb_sum);
        if (!grant && req_valid[arb_idx]) begin
          grant  = 1'b1;
          winner = arb_idx;
        end
      end
    end
  end

  // One-hot ready and winner address, built with constant selects only.
  always_comb begin
    req_ready  = '0;
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && int'(winner) == i) begin
        req_ready[i] = 1'b1;
        grant_addr   = req_addr[i*AW +: AW];
      end
    end
  end

  assign ptr_d = (int'(winner) == NREQ - 1) ? '0 : IDW'(int'(winner) + 1);

  // Register 0 reads as zero regardless of what the mux returns.
`ifdef WRITE_BYPASS_EN
  always_comb begin
    if (a_addr_q == '0)
      rsp_data_d = '0;
    else if (wr_en && wr_addr == a_addr_q)
      rsp_data_d = wr_data;
    else
      rsp_data_d = rf_data;
  end
`else
  assign rsp_data_d = (a_addr_q == '0) ? '0 : rf_data;

  // The write port exists for interface compatibility but has no effect.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would let stage B see stage A's
  // new contents in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q     <= 1'b0;
      a_id_q        <= '0;
      a_addr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      ptr_q         <= '0;
      grant_count_q <= '0;
    end else begin
      if (adv_a) begin
        a_valid_q <= grant;
        if (grant) begin
          a_id_q        <= winner;
          a_addr_q      <= grant_addr;
          ptr_q         <= ptr_d;
          grant_count_q <= grant_count_q + 16'd1;
        end
      end
      if (adv_b) begin
        rsp_valid_q <= a_valid_q;
        rsp_id_q    <= a_id_q;
        rsp_data_q  <= rsp_data_d;
      end
    end
  end

  assign rf_addr     = a_addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_read_port_arbiter
//
// Self-checking bench for rf_read_port_arbiter. A transaction-level model
// (queue of in-flight reads in grant order, round-robin pointer, grant
// counter) predicts grants and responses. The register file is an array in
// the bench whose read data follows rf_addr combinationally; writes land at
// the clock edge.
// ---------------------------------------------------------------------------
module tb_rf_read_port_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_data;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready = 1'b1;
  logic [15:0]       grant_count;

  logic [DW-1:0] rf_mem [32];
  assign rf_data = rf_mem[rf_addr];

  always #5 clk = ~clk;

  rf_read_port_arbiter #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .grant_count(grant_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    bit            in_b;
    logic [DW-1:0] data;
  } item_t;

  item_t         mq[$];
  int            m_ptr = 0;
  logic [15:0]   m_count = '0;
  logic [AW-1:0] m_last_addr = '0;
  int            n_grants = 0;
  int            n_rsps = 0;

  int            exp_winner;
  logic [NREQ-1:0] exp_ready = '0;
  logic          exp_rsp_valid;
  int            exp_rsp_id;
  logic [DW-1:0] exp_rsp_data;

  task automatic model_reset();
    mq.delete();
    m_ptr = 0;
    m_count = '0;
    m_last_addr = '0;
    n_grants = 0;
    n_rsps = 0;
  endtask

  // Two reads in flight means both stages are full, so only an accepted
  // response frees room for a new grant.
  task automatic model_eval();
    bit can_adv;
    can_adv = rst_n && (mq.size() < 2 || rsp_ready);
    exp_winner = -1;
    if (can_adv) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (exp_winner < 0 && req_valid[i]) exp_winner = i;
      end
    end
    exp_ready     = (exp_winner >= 0) ? (NREQ'(1) << exp_winner) : '0;
    exp_rsp_valid = (mq.size() > 0) && mq[0].in_b;
    exp_rsp_id    = (mq.size() > 0) ? mq[0].id : 0;
    exp_rsp_data  = (mq.size() > 0) ? mq[0].data : '0;
  endtask

  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef WRITE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return rf_mem[a];
  endfunction

  // Advance one clock: update the model from pre-edge inputs, let the edge
  // happen, apply any register file write, and return at the falling edge.
  task automatic tick();
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    item_t         h;
    model_eval();
    we = wr_en; wa = wr_addr; wd = wr_data;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) n_rsps++;
      if (exp_rsp_valid && rsp_ready) void'(mq.pop_front());
      if (mq.size() > 0 && !mq[0].in_b) begin
        h = mq[0]; h.in_b = 1'b1; h.data = ref_read(h.addr); mq[0] = h;
      end
      if (exp_winner >= 0) begin
        h.id = exp_winner; h.addr = req_addr[exp_winner*AW +: AW];
        h.in_b = 1'b0; h.data = '0;
        mq.push_back(h);
        m_ptr = (exp_winner + 1) % NREQ;
        m_count = m_count + 16'd1;
        m_last_addr = h.addr;
        n_grants++;
      end
    end
    @(posedge clk); #1;
    if (we) rf_mem[wa] = wd;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rf_addr !== '0) begin n_fail++; $display("FAIL reset_rf_addr: got %h want 00", rf_addr); end
    n_checks++; if (grant_count !== 16'h0) begin n_fail++; $display("FAIL reset_grant_count: got %h want 0000", grant_count); end
    @(negedge clk); @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    rf_mem[5] = 32'hDEADBEEF;
    req_valid = 4'b0001; req_addr[0 +: AW] = 5'd5; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
    n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rsp_data: got %h want deadbeef", rsp_data); end
    n_checks++; if (grant_count !== 16'd1) begin n_fail++; $display("FAIL single_grant_count: got %0d want 1", grant_count); end
    tick();
  endtask

  task automatic test_round_robin();
    int start;
    int gid;
    start = m_ptr;
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(8 + 3*i);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      n_checks++;
      if (req_ready !== (NREQ'(1) << ((start + k) % NREQ))) begin
        n_fail++; $display("FAIL rr_grant cycle %0d: got %b want one-hot %0d", k, req_ready, (start + k) % NREQ);
      end
      if (k >= 2) begin
        gid = (start + k - 2) % NREQ;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid cycle %0d: got %b want 1", k, rsp_valid); end
        n_checks++; if (int'(rsp_id) != gid) begin n_fail++; $display("FAIL rr_rsp_id cycle %0d: got %0d want %0d", k, rsp_id, gid); end
        n_checks++; if (rsp_data !== rf_mem[8 + 3*gid]) begin n_fail++; $display("FAIL rr_rsp_data cycle %0d: got %h want %h", k, rsp_data, rf_mem[8 + 3*gid]); end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [IDW-1:0] s_id;
    logic [DW-1:0]  s_data;
    logic [AW-1:0]  s_addr;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    tick(); tick(); tick();
    rsp_ready = 1'b0;
    #1;
    model_eval();
    s_id = rsp_id; s_data = rsp_data; s_addr = rf_addr;
    n_checks++; if (int'(rsp_id) != exp_rsp_id || rsp_data !== exp_rsp_data) begin
      n_fail++; $display("FAIL bp_head: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, exp_rsp_id, exp_rsp_data);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready cycle %0d: got %b want 0000", k, req_ready); end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid cycle %0d: got %b want 1", k, rsp_valid); end
      n_checks++; if (rsp_id !== s_id || rsp_data !== s_data) begin n_fail++; $display("FAIL bp_rsp_hold cycle %0d: got %0d/%h want %0d/%h", k, rsp_id, rsp_data, s_id, s_data); end
      n_checks++; if (rf_addr !== s_addr) begin n_fail++; $display("FAIL bp_rf_addr cycle %0d: got %h want %h", k, rf_addr, s_addr); end
      tick();
    end
    rsp_ready = 1'b1; req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      model_eval();
      n_checks++; if (rsp_valid !== exp_rsp_valid) begin n_fail++; $display("FAIL bp_drain_valid cycle %0d: got %b want %b", k, rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid) begin
        n_checks++; if (int'(rsp_id) != exp_rsp_id || rsp_data !== exp_rsp_data) begin
          n_fail++; $display("FAIL bp_drain_rsp cycle %0d: got %0d/%h want %0d/%h", k, rsp_id, rsp_data, exp_rsp_id, exp_rsp_data);
        end
      end
      tick();
    end
    n_checks++; if (n_rsps != n_grants) begin n_fail++; $display("FAIL bp_lost: got %0d responses want %0d", n_rsps, n_grants); end
  endtask

  task automatic test_addr_zero();
    rf_mem[0] = 32'hFFFFFFFF;
    req_valid = 4'b0100; req_addr[2*AW +: AW] = '0; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL addr_zero: got valid %b data %h want 1/00000000", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_write_bypass();
    logic [DW-1:0] want;
`ifdef WRITE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    rf_mem[7] = 32'h11;
    req_valid = 4'b0010; req_addr[1*AW +: AW] = 5'd7; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22;
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== want) begin
      n_fail++; $display("FAIL write_bypass: got valid %b data %h want 1/%h", rsp_valid, rsp_data, want);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b1111; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (grant_count !== 16'h0) begin n_fail++; $display("FAIL mid_reset_count: got %h want 0000", grant_count); end
    n_checks++; if (rf_addr !== '0) begin n_fail++; $display("FAIL mid_reset_rf_addr: got %h want 00", rf_addr); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_req_ready: got %b want 0000", req_ready); end
    model_reset();
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_ptr: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      model_eval();
      n_checks++; if (rsp_valid !== exp_rsp_valid) begin n_fail++; $display("FAIL mid_reset_stale cycle %0d: got %b want %b", k, rsp_valid, exp_rsp_valid); end
      tick();
    end
    n_checks++; if (n_rsps != 1 || n_grants != 1) begin n_fail++; $display("FAIL mid_reset_count_rsp: got %0d responses %0d grants want 1/1", n_rsps, n_grants); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !exp_ready[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(1) == 1);
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      wr_en     = ($urandom_range(2) == 0);
      wr_addr   = ($urandom_range(1) == 1) ? m_last_addr : AW'($urandom);
      wr_data   = $urandom;
      #1;
      model_eval();
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_req_ready cycle %0d: got %b want %b", c, req_ready, exp_ready); end
      n_checks++; if (rsp_valid !== exp_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid cycle %0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid) begin
        n_checks++; if (int'(rsp_id) != exp_rsp_id || rsp_data !== exp_rsp_data) begin
          n_fail++; $display("FAIL rnd_rsp cycle %0d: got %0d/%h want %0d/%h", c, rsp_id, rsp_data, exp_rsp_id, exp_rsp_data);
        end
      end
      n_checks++; if (grant_count !== m_count) begin n_fail++; $display("FAIL rnd_grant_count cycle %0d: got %0d want %0d", c, grant_count, m_count); end
      n_checks++; if (rf_addr !== m_last_addr) begin n_fail++; $display("FAIL rnd_rf_addr cycle %0d: got %h want %h", c, rf_addr, m_last_addr); end
      tick();
    end
    req_valid = '0; wr_en = 1'b0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (n_rsps != n_grants) begin n_fail++; $display("FAIL rnd_lost: got %0d responses want %0d", n_rsps, n_grants); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_addr_zero();
    test_write_bypass();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_read_port_arbiter.md
Name: rf_read_port_arbiter

Overview:
Shares the single read port of the 32 x 32-bit register file (5-bit address into the 32:1 by-32 read multiplexer) among NREQ requesters. Each requester uses a valid/ready request handshake and receives tagged read data through a single backpressured response channel. The block uses round-robin arbitration and a 2-stage pipeline (issue, response), with one read per cycle when there is no stall.

Parameters:
NREQ, 4, number of requesters; legal values 2..8.
IDW, 2, requester ID width; must equal clog2(NREQ).
AW, 5, register address width.
DW, 32, register data width.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester read request
req_addr  input  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW]
req_ready  output  NREQ  one-hot grant, combinational
rf_addr  output  AW  registered read address to the register file mux select
rf_data  input  DW  combinational read data from the register file mux
wr_en  input  1  register file write enable (used only for bypass)
wr_addr  input  AW  register file write address
wr_data  input  DW  register file write data
rsp_valid  output  1  response valid
rsp_id  output  IDW  ID of the requester the response belongs to
rsp_data  output  DW  read data
rsp_ready  input  1  response consumer accepts
grant_count  output  16  total grants since reset; wraps 0xFFFF -> 0

Behaviour:
- Stage A registers: a_valid, a_id, a_addr. rf_addr = a_addr.
- Stage B registers: rsp_valid, rsp_id, rsp_data.
- advB = !rsp_valid || rsp_ready.
- advA = !a_valid || advB.
- Arbitration runs only when advA=1.
  - Winner is the first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - When advA=0, req_ready is all 0.
  - req_ready may depend combinationally on req_valid.
- On a grant, on the clock edge:
  - a_valid<=1, a_id<=winner, a_addr<=req_addr[winner].
  - ptr<=(winner+1) mod NREQ.
  - grant_count increments.
- advA=1 with no grant: a_valid<=0; ptr unchanged.
- advB=1: rsp_valid<=a_valid, rsp_id<=a_id, rsp_data<=(a_addr==0 ? 0 : rf_data).
- advB=0: stage B holds. If a_valid=1, stage A also holds and rf_addr stays stable.
- Latency: grant at edge N -> rsp_valid=1 after edge N+1 (two edges after the request cycle). Throughput is 1 per cycle when rsp_ready is held at 1.
- Requester rule: req_addr must stay stable while req_valid=1 and req_ready=0. A requester may deassert req_valid before it is granted.
- Ordering: responses are returned in grant order. There is no reordering and no dropping under backpressure.
- Reset (asserted at any time, including mid-operation):
  - Clears a_valid, rsp_valid, a_id, rsp_id, a_addr (so rf_addr=0), rsp_data, ptr and grant_count, all to 0.
  - In-flight reads are discarded.
  - req_ready is 0 while rst_n=0.
- Full pipeline: both stages valid and rsp_ready=0 -> no grants. After rsp_ready returns to 1, both stages advance in the same cycle.
- Same requester may be granted again the next cycle only if no other requester is valid (ptr has moved past it).

Optional Feature:
WRITE_BYPASS_EN
- Defined: at the stage-B capture edge, if wr_en=1 and wr_addr==a_addr and a_addr!=0, then rsp_data<=wr_data instead of rf_data. This forwards a same-cycle register file write.
- Not defined: the wr_en, wr_addr and wr_data ports are still present but ignored; rsp_data always comes from rf_data (or 0 for address 0).

Test Plan:
1. Reset, then requester 0 only with addr=5 and rf model reg5=0xDEADBEEF -> req_ready=4'b0001 in the request cycle; two edges later rsp_valid=1, rsp_id=0, rsp_data=0xDEADBEEF; grant_count=1.
2. All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,...; rsp_id sequence matches; one response per cycle after 2-cycle fill.
3. 3 back-to-back grants, then rsp_ready=0 for 5 cycles -> rsp_valid held with rsp_id/rsp_data stable, rf_addr stable, req_ready=0; on release, remaining responses arrive in order with none lost.
4. Request addr=0 while rf_data is forced to 0xFFFFFFFF -> rsp_data=0x00000000.
5. With WRITE_BYPASS_EN defined, read addr=7 (old value 0x11) while wr_en=1, wr_addr=7, wr_data=0x22 in the capture cycle -> rsp_data=0x22. Without the macro -> 0x11.
6. Assert rst_n=0 for 1 cycle with 2 reads in flight -> rsp_valid=0 immediately, ptr=0, grant_count=0; no stale responses after release.
